// File: rtl/lv2_bus_responder_if.sv
// ---------------------------------------------------------------------------
// lv2_bus_responder_if
// Request/handshake bundle between the granted L1 cache (master) and the
// level-2 responder (slave).
//   addr_bus_lv1_lv2 : request address, master -> slave
//   lv2_rd           : read request, held by L1 until read data is seen
//   lv2_wr           : write request, held by L1 until lv2_wr_done
//   lv2_wr_done      : write completion, slave -> master
// The shared tri-state lines (data_bus_lv1_lv2, data_in_bus_lv1_lv2) stay
// as plain inout ports on the responder so they resolve as ordinary nets.
// ---------------------------------------------------------------------------
interface lv2_bus_responder_if #(
   parameter int ADDR_WID = 32
);
   logic [ADDR_WID-1:0] addr_bus_lv1_lv2;
   logic                lv2_rd;
   logic                lv2_wr;
   logic                lv2_wr_done;

   modport master (
      output addr_bus_lv1_lv2,
      output lv2_rd,
      output lv2_wr,
      input  lv2_wr_done
   );

   modport slave (
      input  addr_bus_lv1_lv2,
      input  lv2_rd,
      input  lv2_wr,
      output lv2_wr_done
   );
endinterface

// File: rtl/lv2_bus_responder.sv
// ---------------------------------------------------------------------------
// lv2_bus_responder
// Level-2 responder for the L1<->L2 bus. Accepts one read or write at a time
// from the granted core, serves it from a word-addressed store after a fixed
// latency, and completes it with the L1 handshake:
//   read  : data_in_bus_lv1_lv2 = 1 with the word on data_bus_lv1_lv2
//   write : lv2_wr_done = 1
// Ports:
//   clk                 : clock, rising edge only
//   rst                 : synchronous active-high reset
//   bus                 : request/handshake bundle (slave side)
//   data_bus_lv1_lv2    : write data in / read data out, 'z when not driving
//   data_in_bus_lv1_lv2 : 1 while read data is valid, 'z otherwise
// All outputs come straight from registers; the store is never reset.
// ---------------------------------------------------------------------------
module lv2_bus_responder #(
   parameter int DATA_WID   = 32,
   parameter int ADDR_WID   = 32,
   parameter int MEM_AW     = 10,
   parameter int IDX_LSB    = 2,
   parameter int RD_LATENCY = 4,
   parameter int WR_LATENCY = 4
) (
   input  logic                clk,
   input  logic                rst,
   lv2_bus_responder_if.slave  bus,
   inout  wire  [DATA_WID-1:0] data_bus_lv1_lv2,
   inout  wire                 data_in_bus_lv1_lv2
);

   localparam int MAX_LAT = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
   localparam int CNT_W   = $clog2(MAX_LAT + 1);
   localparam int DEPTH   = 1 << MEM_AW;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_WAIT,
      S_RD_DRIVE,
      S_WR_WAIT,
      S_WR_DONE
   } state_t;

   state_t              r_state;
   logic [CNT_W-1:0]    r_cnt;
   logic [MEM_AW-1:0]   r_idx;
   logic [DATA_WID-1:0] r_wdata;
   logic [DATA_WID-1:0] r_rdata;
   logic                r_drive;
   logic                r_wr_done;
   logic [DATA_WID-1:0] r_mem [0:DEPTH-1];

   logic [ADDR_WID-1:0] w_addr;
   logic [MEM_AW-1:0]   w_idx;
   logic                w_mem_we;
   logic                w_mem_re;
   logic                w_unused_addr;

   assign w_addr        = bus.addr_bus_lv1_lv2;
   assign w_idx         = w_addr[IDX_LSB +: MEM_AW];
   // Address bits outside the word index carry no meaning here.
   assign w_unused_addr = ^w_addr;

   // Store access happens on the same edge the FSM leaves its WAIT state,
   // so the request must still be held and reset must not be active.
   assign w_mem_we = !rst && (r_state == S_WR_WAIT) && bus.lv2_wr && (r_cnt == '0);
   assign w_mem_re = !rst && (r_state == S_RD_WAIT) && bus.lv2_rd && (r_cnt == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_idx     <= '0;
         r_wdata   <= '0;
         r_drive   <= 1'b0;
         r_wr_done <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               // Write has priority when both requests arrive together.
               if (bus.lv2_wr) begin
                  r_state <= S_WR_WAIT;
                  r_idx   <= w_idx;
                  r_wdata <= data_bus_lv1_lv2;
                  r_cnt   <= CNT_W'(WR_LATENCY - 1);
               end else if (bus.lv2_rd) begin
                  r_state <= S_RD_WAIT;
                  r_idx   <= w_idx;
                  r_cnt   <= CNT_W'(RD_LATENCY - 1);
               end
            end
            S_RD_WAIT: begin
               // A dropped request aborts even on the final latency cycle.
               if (!bus.lv2_rd) begin
                  r_state <= S_IDLE;
               end else if (r_cnt == '0) begin
                  r_state <= S_RD_DRIVE;
                  r_drive <= 1'b1;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            S_RD_DRIVE: begin
               if (!bus.lv2_rd) begin
                  r_state <= S_IDLE;
                  r_drive <= 1'b0;
               end
            end
            S_WR_WAIT: begin
               if (!bus.lv2_wr) begin
                  r_state <= S_IDLE;
               end else if (r_cnt == '0) begin
                  r_state   <= S_WR_DONE;
                  r_wr_done <= 1'b1;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            S_WR_DONE: begin
               if (!bus.lv2_wr) begin
                  r_state   <= S_IDLE;
                  r_wr_done <= 1'b0;
               end
            end
            default: begin
               r_state   <= S_IDLE;
               r_drive   <= 1'b0;
               r_wr_done <= 1'b0;
            end
         endcase
      end
   end

   // Backing store: kept free of reset so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (w_mem_we) begin
         r_mem[r_idx] <= r_wdata;
      end
      if (w_mem_re) begin
         r_rdata <= r_mem[r_idx];
      end
   end

   assign bus.lv2_wr_done     = r_wr_done;
   assign data_bus_lv1_lv2    = r_drive ? r_rdata : {DATA_WID{1'bz}};
   assign data_in_bus_lv1_lv2 = r_drive ? 1'b1 : 1'bz;

endmodule

// File: tb/tb_lv2_bus_responder.sv
// ---------------------------------------------------------------------------
// tb_lv2_bus_responder
// Transaction-level model: each read/write task knows from the request
// timing alone which cycles must show done / valid data, and a word map
// holds the committed store contents. A single process compares the DUT
// outputs to those expectations on every falling edge.
// ---------------------------------------------------------------------------
module tb_lv2_bus_responder;

   localparam int DATA_WID = 32;
   localparam int ADDR_WID = 32;
   localparam int MEM_AW   = 10;
   localparam int IDX_LSB  = 2;
   localparam int RD_LAT   = 4;
   localparam int WR_LAT   = 4;
   localparam int DEPTH    = 1 << MEM_AW;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   lv2_bus_responder_if #(.ADDR_WID(ADDR_WID)) bus_if ();

   logic                tb_drv;
   logic [DATA_WID-1:0] tb_data;
   wire  [DATA_WID-1:0] data_bus;
   wire                 data_in;

   assign data_bus = tb_drv ? tb_data : {DATA_WID{1'bz}};

   lv2_bus_responder #(
      .DATA_WID   (DATA_WID),
      .ADDR_WID   (ADDR_WID),
      .MEM_AW     (MEM_AW),
      .IDX_LSB    (IDX_LSB),
      .RD_LATENCY (RD_LAT),
      .WR_LATENCY (WR_LAT)
   ) dut (
      .clk                 (clk),
      .rst                 (rst),
      .bus                 (bus_if),
      .data_bus_lv1_lv2    (data_bus),
      .data_in_bus_lv1_lv2 (data_in)
   );

   // Expected outputs after the most recent rising edge.
   logic                exp_valid;
   logic                exp_known;
   logic [DATA_WID-1:0] exp_data;
   logic                exp_done;
   logic                chk_en;

   int ntests = 0;
   int nfail  = 0;

   bit [DATA_WID-1:0] mdl_mem [int];

   int                last_wr_lat;
   int                last_rd_lat;
   logic [DATA_WID-1:0] last_rd_data;

   function automatic int index_of(input logic [ADDR_WID-1:0] a);
      return int'((a >> IDX_LSB) & (DEPTH - 1));
   endfunction

   function automatic logic [ADDR_WID-1:0] make_addr(input int idx);
      logic [ADDR_WID-1:0] a;
      a = $urandom;
      a = a & ~(ADDR_WID'(DEPTH - 1) << IDX_LSB);
      return a | (ADDR_WID'(idx) << IDX_LSB);
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic check32(input string name, input logic [31:0] got, input logic [31:0] req);
      ntests++;
      if (got !== req) begin
         nfail++;
         $display("FAIL %s: got %h required %h", name, got, req);
      end
   endtask

   task automatic check_int(input string name, input int got, input int req);
      ntests++;
      if (got != req) begin
         nfail++;
         $display("FAIL %s: got %0d required %0d", name, got, req);
      end
   endtask

   // Per-cycle comparison against the expectation variables.
   always @(negedge clk) begin
      if (chk_en) begin
         ntests++;
         if (bus_if.lv2_wr_done !== exp_done) begin
            nfail++;
            $display("FAIL wr_done @%0t: got %b required %b", $time, bus_if.lv2_wr_done, exp_done);
         end
         if (exp_valid) begin
            ntests++;
            if (data_in !== 1'b1) begin
               nfail++;
               $display("FAIL rd_valid @%0t: got %b required 1", $time, data_in);
            end
            if (exp_known) begin
               ntests++;
               if (data_bus !== exp_data) begin
                  nfail++;
                  $display("FAIL rd_data @%0t: got %h required %h", $time, data_bus, exp_data);
               end
            end
         end else begin
            ntests++;
            if (data_in === 1'b1) begin
               nfail++;
               $display("FAIL valid_release @%0t: got 1 required z", $time);
            end
            if (!tb_drv) begin
               ntests++;
               if (!($isunknown(data_bus) || data_bus == '0)) begin
                  nfail++;
                  $display("FAIL data_release @%0t: got %h required z", $time, data_bus);
               end
            end
         end
      end
   end

   // Write: abort_k>0 drops lv2_wr so it is sampled low abort_k edges after
   // acceptance; rst_k>0 hits reset at that edge instead. both also raises lv2_rd.
   task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                           input int abort_k, input int hold, input bit both, input int rst_k);
      int idx;
      int first;
      int j;
      idx   = index_of(addr);
      first = -1;
      tb_drv = 1'b1;
      tb_data = data;
      bus_if.addr_bus_lv1_lv2 = addr;
      bus_if.lv2_wr = 1'b1;
      bus_if.lv2_rd = both;
      cyc();                      // acceptance edge
      bus_if.addr_bus_lv1_lv2 = $urandom;
      tb_data = $urandom;
      if (rst_k > 0) begin
         for (j = 1; j < rst_k; j++) cyc();
         rst = 1'b1;
         cyc();
         rst = 1'b0;
         bus_if.lv2_wr = 1'b0;
         bus_if.lv2_rd = 1'b0;
         cyc();
      end else if (abort_k > 0) begin
         for (j = 1; j < abort_k; j++) cyc();
         bus_if.lv2_wr = 1'b0;
         bus_if.lv2_rd = 1'b0;
         cyc();
      end else begin
         for (j = 1; j <= WR_LAT + hold; j++) begin
            cyc();
            if (j == WR_LAT) begin
               exp_done = 1'b1;
               mdl_mem[idx] = data;
            end
            @(negedge clk);
            #1;
            if (first < 0 && bus_if.lv2_wr_done === 1'b1) first = j;
         end
         bus_if.lv2_wr = 1'b0;
         bus_if.lv2_rd = 1'b0;
         cyc();
         exp_done = 1'b0;
      end
      tb_drv = 1'b0;
      last_wr_lat = first;
      $display("[TB] write idx=%0d data=%h abort=%0d rst=%0d both=%0d hold=%0d lat=%0d",
               idx, data, abort_k, rst_k, both, hold, first);
   endtask

   // Read: abort_k>0 drops lv2_rd before data; rst_drive resets while driving
   // with lv2_rd still high, which must start a fresh full-latency read.
   task automatic do_read(input logic [31:0] addr, input int abort_k, input int hold,
                          input bit rst_drive);
      int idx;
      int first;
      int j;
      int npass;
      logic [DATA_WID-1:0] got;
      idx   = index_of(addr);
      first = -1;
      got   = '0;
      npass = rst_drive ? 2 : 1;
      tb_drv = 1'b0;
      bus_if.lv2_rd = 1'b1;
      for (int pass = 0; pass < npass; pass++) begin
         first = -1;
         bus_if.addr_bus_lv1_lv2 = addr;
         cyc();                   // acceptance edge
         bus_if.addr_bus_lv1_lv2 = $urandom;
         if (abort_k > 0) begin
            for (j = 1; j < abort_k; j++) cyc();
            bus_if.lv2_rd = 1'b0;
            cyc();
         end else begin
            for (j = 1; j <= RD_LAT + hold; j++) begin
               cyc();
               if (j == RD_LAT) begin
                  exp_valid = 1'b1;
                  exp_known = mdl_mem.exists(idx);
                  exp_data  = exp_known ? mdl_mem[idx] : '0;
               end
               @(negedge clk);
               #1;
               if (first < 0 && data_in === 1'b1) begin
                  first = j;
                  got   = data_bus;
               end
            end
            if (rst_drive && pass == 0) begin
               rst = 1'b1;
               cyc();
               exp_valid = 1'b0;
               rst = 1'b0;
            end else begin
               bus_if.lv2_rd = 1'b0;
               cyc();
               exp_valid = 1'b0;
            end
         end
      end
      exp_known = 1'b0;
      last_rd_lat  = first;
      last_rd_data = got;
      $display("[TB] read  idx=%0d data=%h abort=%0d rst=%0d hold=%0d lat=%0d",
               idx, got, abort_k, rst_drive, hold, first);
   endtask

   initial begin
      int idx;
      int op;
      rst = 1'b1;
      bus_if.lv2_rd = 1'b0;
      bus_if.lv2_wr = 1'b0;
      bus_if.addr_bus_lv1_lv2 = '0;
      tb_drv = 1'b0;
      tb_data = '0;
      exp_valid = 1'b0;
      exp_known = 1'b0;
      exp_data = '0;
      exp_done = 1'b0;
      chk_en = 1'b0;
      last_wr_lat = -1;
      last_rd_lat = -1;
      last_rd_data = '0;
      repeat (3) cyc();
      chk_en = 1'b1;
      rst = 1'b0;
      cyc();

      // Directed sequence with literal expectations.
      do_write(32'h0000_0040, 32'hDEAD_BEEF, 0, 1, 1'b0, 0);
      check_int("wr40_latency", last_wr_lat, 4);
      do_read(32'h0000_0040, 0, 2, 1'b0);
      check_int("rd40_latency", last_rd_lat, 4);
      check32("rd40_data", last_rd_data, 32'hDEAD_BEEF);

      do_write(32'h0000_0014, 32'h0000_0000, 0, 0, 1'b0, 0);
      do_write(32'h0000_0014, 32'h0000_0001, 2, 0, 1'b0, 0);
      check_int("wr5_abort_no_done", last_wr_lat, -1);
      do_read(32'h0000_0014, 0, 0, 1'b0);
      check32("rd5_after_abort", last_rd_data, 32'h0000_0000);

      do_write(32'h0000_0080, 32'h0000_0055, 0, 0, 1'b1, 0);
      check_int("both_wr_latency", last_wr_lat, 4);
      do_read(32'h0000_0080, 0, 1, 1'b0);
      check32("rd80_data", last_rd_data, 32'h0000_0055);

      do_read(32'h0000_0040, 0, 1, 1'b1);
      check_int("rst_drive_relatency", last_rd_lat, 4);
      check32("rst_drive_data", last_rd_data, 32'hDEAD_BEEF);

      do_write(32'h0000_0100, 32'hA5A5_1234, 0, 0, 1'b0, 0);
      do_read(32'h0000_0100, 0, 0, 1'b0);
      check_int("b2b_rd_latency", last_rd_lat, 4);
      check32("b2b_rd_data", last_rd_data, 32'hA5A5_1234);

      do_write(32'h0000_0040, 32'h1234_5678, 0, 0, 1'b0, 2);
      check_int("rst_wr_no_done", last_wr_lat, -1);
      do_read(32'h0000_0040, 0, 0, 1'b0);
      check32("rst_wr_mem_kept", last_rd_data, 32'hDEAD_BEEF);

      // Randomized traffic over a small index pool so reads hit written words.
      for (int t = 0; t < 80; t++) begin
         op  = $urandom_range(0, 9);
         idx = $urandom_range(0, 15);
         if (op < 4) begin
            do_write(make_addr(idx), $urandom,
                     ($urandom_range(0, 3) == 0) ? $urandom_range(1, WR_LAT - 1) : 0,
                     $urandom_range(0, 3), $urandom_range(0, 4) == 0, 0);
         end else if (op == 4) begin
            do_write(make_addr(idx), $urandom, 0, 0, 1'b0, $urandom_range(1, WR_LAT - 1));
         end else if (op == 5) begin
            do_read(make_addr(idx), $urandom_range(1, RD_LAT - 1), 0, 1'b0);
         end else begin
            do_read(make_addr(idx), 0, $urandom_range(0, 3), $urandom_range(0, 5) == 0);
         end
      end

      repeat (2) cyc();
      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
